// File: rtl/response_resolver_if.sv
// Command/status bundle between the array controller and the responder-resolution stage.
interface response_resolver_if #(
    parameter int num_cells = 100,
    parameter int idx_bits  = 7
);
    logic [num_cells-1:0] match_lines;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [num_cells-1:0] tags;
    logic                 some;
    logic                 none;
    logic [idx_bits-1:0]  first_idx;
    logic                 enum_done;

    // Controller side: issues commands and presents the array match lines.
    modport master (
        output match_lines, cmd_valid, cmd_op,
        input  cmd_ready, tags, some, none, first_idx, enum_done
    );

    // Resolver side: accepts commands and drives tags and responder status.
    modport slave (
        input  match_lines, cmd_valid, cmd_op,
        output cmd_ready, tags, some, none, first_idx, enum_done
    );
endinterface

// File: rtl/response_resolver.sv
// Tag register and responder resolver for the associative cell array.
// Holds the tag vector that gates array access, reports whether any cell
// responds and which is first, and enumerates responders one at a time.
module response_resolver #(
    parameter int num_cells = 100,
    parameter int idx_bits  = 7
) (
    input logic                CLK,
    input logic                RST_N,
    response_resolver_if.slave bus
);
    typedef logic [num_cells-1:0] cells_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ENUM  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_SET_ALL   = 3'd1,
        OP_CLR_ALL   = 3'd2,
        OP_LOAD      = 3'd3,
        OP_AND       = 3'd4,
        OP_OR        = 3'd5,
        OP_SEL_FIRST = 3'd6,
        OP_NEXT      = 3'd7
    } op_t;

    // Isolates the lowest set bit (two's-complement trick).
    function automatic cells_t lowest_bit(input cells_t v);
        return v & (~v + cells_t'(1));
    endfunction

    // Clears the lowest set bit.
    function automatic cells_t drop_lowest(input cells_t v);
        return v & (v - cells_t'(1));
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [idx_bits-1:0] first_set(input cells_t v);
        logic [idx_bits-1:0] idx;
        idx = '0;
        for (int i = num_cells - 1; i >= 0; i--) begin
            if (v[i]) idx = idx_bits'(i);
        end
        return idx;
    endfunction

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    cells_t              tags_q, tags_d;
    cells_t              pending_q, pending_d;
    cells_t              cap_q, cap_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                some_q, some_d;
    logic                none_q, none_d;
    logic [idx_bits-1:0] first_idx_q, first_idx_d;
    logic                enum_done_q, enum_done_d;

    op_t  cmd_op_w;
    logic accept_w;

    assign cmd_op_w = op_t'(bus.cmd_op);
    assign accept_w = bus.cmd_valid && cmd_ready_q;

    // Next-state, tag update and status derivation from the next tag value.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tags_d      = tags_q;
        pending_d   = pending_q;
        cap_d       = cap_q;
        cmd_ready_d = cmd_ready_q;
        enum_done_d = 1'b0;

        if (state_q == APPLY) begin
            // Second cycle of LOAD/AND/OR: combine the captured match lines.
            case (op_q)
                OP_LOAD: tags_d = cap_q;
                OP_AND:  tags_d = tags_q & cap_q;
                OP_OR:   tags_d = tags_q | cap_q;
                default: tags_d = tags_q;
            endcase
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
        end else if (accept_w) begin
            // Anything but NOP/NEXT abandons an enumeration in progress.
            if (state_q == ENUM && cmd_op_w != OP_NOP && cmd_op_w != OP_NEXT) begin
                pending_d = '0;
                state_d   = IDLE;
            end
            case (cmd_op_w)
                OP_SET_ALL: tags_d = '1;
                OP_CLR_ALL: tags_d = '0;
                OP_LOAD, OP_AND, OP_OR: begin
                    cap_d       = bus.match_lines;
                    op_d        = cmd_op_w;
                    cmd_ready_d = 1'b0;
                    state_d     = APPLY;
                end
                OP_SEL_FIRST: begin
                    if (|tags_q) begin
                        pending_d = drop_lowest(tags_q);
                        tags_d    = lowest_bit(tags_q);
                        state_d   = ENUM;
                    end else begin
                        enum_done_d = 1'b1;
                    end
                end
                OP_NEXT: begin
                    if (state_q == ENUM) begin
                        if (|pending_q) begin
                            tags_d    = lowest_bit(pending_q);
                            pending_d = drop_lowest(pending_q);
                        end else begin
                            tags_d      = '0;
                            enum_done_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end

        some_d      = |tags_d;
        none_d      = ~some_d;
        first_idx_d = first_set(tags_d);
    end

    // State and registered outputs; reset abandons any in-flight command.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            op_q        <= OP_NOP;
            tags_q      <= '0;
            pending_q   <= '0;
            cap_q       <= '0;
            cmd_ready_q <= 1'b1;
            some_q      <= 1'b0;
            none_q      <= 1'b1;
            first_idx_q <= '0;
            enum_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tags_q      <= tags_d;
            pending_q   <= pending_d;
            cap_q       <= cap_d;
            cmd_ready_q <= cmd_ready_d;
            some_q      <= some_d;
            none_q      <= none_d;
            first_idx_q <= first_idx_d;
            enum_done_q <= enum_done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.tags      = tags_q;
    assign bus.some      = some_q;
    assign bus.none      = none_q;
    assign bus.first_idx = first_idx_q;
    assign bus.enum_done = enum_done_q;
endmodule

// File: tb/tb_response_resolver.sv
// Scoreboard bench for response_resolver: a reference model pushes the
// expected outputs of each command, which are popped once the command completes.
module tb_response_resolver;
    localparam int N  = 100;
    localparam int IB = 7;

    typedef struct {
        logic [N-1:0]  tags;
        logic          some;
        logic [IB-1:0] idx;
        logic          done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    logic [N-1:0] m_tags;
    logic [N-1:0] m_pend;
    logic         m_enum;

    response_resolver_if #(.num_cells(N), .idx_bits(IB)) bus ();

    response_resolver #(.num_cells(N), .idx_bits(IB)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model of one accepted command; pushes the expected result.
    task automatic model(input logic [2:0] op, input logic [N-1:0] m);
        exp_t e;
        int   k;
        e.done = 1'b0;
        if (m_enum && op != 3'd0 && op != 3'd7) begin
            m_pend = '0;
            m_enum = 1'b0;
        end
        case (op)
            3'd1: m_tags = '1;
            3'd2: m_tags = '0;
            3'd3: m_tags = m;
            3'd4: m_tags = m_tags & m;
            3'd5: m_tags = m_tags | m;
            3'd6: begin
                k = lowest(m_tags);
                if (k >= 0) begin
                    m_pend    = m_tags;
                    m_pend[k] = 1'b0;
                    m_tags    = '0;
                    m_tags[k] = 1'b1;
                    m_enum    = 1'b1;
                end else begin
                    e.done = 1'b1;
                end
            end
            3'd7: begin
                if (m_enum) begin
                    k = lowest(m_pend);
                    if (k >= 0) begin
                        m_tags    = '0;
                        m_tags[k] = 1'b1;
                        m_pend[k] = 1'b0;
                    end else begin
                        m_tags = '0;
                        e.done = 1'b1;
                        m_enum = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        e.tags = m_tags;
        e.some = |m_tags;
        k      = lowest(m_tags);
        e.idx  = (k < 0) ? '0 : IB'(k);
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_tags"}, 128'(bus.tags), 128'(e.tags));
        chk({tag, "_some"}, 128'(bus.some), 128'(e.some));
        chk({tag, "_none"}, 128'(bus.none), 128'(!e.some));
        chk({tag, "_idx"},  128'(bus.first_idx), 128'(e.idx));
        chk({tag, "_done"}, 128'(bus.enum_done), 128'(e.done));
        chk({tag, "_rdy"},  128'(bus.cmd_ready), 128'(1));
    endtask

    // Issue one command at a falling edge and check its outcome when it completes.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [N-1:0] m);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.match_lines = m;
        model(op, m);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (op == 3'd3 || op == 3'd4 || op == 3'd5) begin
            chk({tag, "_rdy_low"}, 128'(bus.cmd_ready), 0);
            @(negedge clk);
        end
        compare_out(tag);
    endtask

    function automatic logic [N-1:0] rnd_vec();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[N-1:0];
    endfunction

    logic [N-1:0] v;

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_tags = '0;
        m_pend = '0;
        m_enum = 1'b0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'd0;
        bus.match_lines = '0;
        repeat (3) @(negedge clk);
        chk("rst_tags", 128'(bus.tags), 0);
        chk("rst_some", 128'(bus.some), 0);
        chk("rst_none", 128'(bus.none), 1);
        chk("rst_idx",  128'(bus.first_idx), 0);
        chk("rst_done", 128'(bus.enum_done), 0);
        chk("rst_rdy",  128'(bus.cmd_ready), 1);
        rst_n = 1'b1;

        do_cmd("load_zero", 3'd3, '0);

        v = '0; v[3] = 1'b1; v[10] = 1'b1; v[99] = 1'b1;
        do_cmd("set_all", 3'd1, '0);
        do_cmd("and_3_10_99", 3'd4, v);
        do_cmd("sel_first", 3'd6, '0);
        do_cmd("next_10", 3'd7, '0);
        do_cmd("next_99", 3'd7, '0);
        do_cmd("next_end", 3'd7, '0);
        @(negedge clk);
        chk("done_pulse_end", 128'(bus.enum_done), 0);
        do_cmd("next_idle", 3'd7, '0);

        do_cmd("reload", 3'd3, v);
        do_cmd("sel_again", 3'd6, '0);
        do_cmd("to_10", 3'd7, '0);
        v = '0; v[50] = 1'b1;
        do_cmd("or_abort", 3'd5, v);
        do_cmd("next_after_abort", 3'd7, '0);

        do_cmd("clr_all", 3'd2, '0);
        do_cmd("sel_empty", 3'd6, '0);

        // Single responder at the top index.
        v = '0; v[N-1] = 1'b1;
        do_cmd("load_single", 3'd3, v);
        do_cmd("sel_single", 3'd6, '0);
        do_cmd("next_single", 3'd7, '0);

        // All cells responding: every index visited in order.
        do_cmd("all_set", 3'd1, '0);
        do_cmd("all_sel", 3'd6, '0);
        for (int i = 1; i <= N; i++) do_cmd("all_next", 3'd7, '0);

        // cmd_valid held high through the APPLY cycle.
        v = rnd_vec();
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'd4;
        bus.match_lines = v;
        model(3'd4, v);
        @(negedge clk);
        bus.cmd_op = 3'd1;
        chk("held_rdy_low", 128'(bus.cmd_ready), 0);
        @(negedge clk);
        compare_out("held_and");
        model(3'd1, '0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        compare_out("held_set");

        // Reset during APPLY discards the captured match value.
        v = rnd_vec() | 100'd1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'd4;
        bus.match_lines = v;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_tags = '0;
        m_pend = '0;
        m_enum = 1'b0;
        chk("rst_apply_tags", 128'(bus.tags), 0);
        chk("rst_apply_rdy",  128'(bus.cmd_ready), 1);
        chk("rst_apply_none", 128'(bus.none), 1);
        @(negedge clk);
        chk("rst_apply_hold", 128'(bus.tags), 0);

        // Random command mix.
        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            do_cmd("rand", op, rnd_vec());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
